// File: rtl/label_definition_collector.sv
// First-pass scanner: records `name:` label definitions with their line pc into a
// small table that the second pass reads through a combinational query port.
// Optional macro LABEL_DUP_CHECK_EN: redefining an already stored label is an error.
module label_definition_collector #(
  parameter int NUMBER_LINES   = 256,
  parameter int NUMBER_LETTERS = 6,
  parameter int STORAGE_SIZE   = 8,
  localparam int PW = $clog2(NUMBER_LINES),
  localparam int LW = NUMBER_LETTERS * 5,
  localparam int CW = $clog2(STORAGE_SIZE) + 1,
  localparam int NW = $clog2(NUMBER_LETTERS + 1),
  localparam int IW = (STORAGE_SIZE > 1) ? $clog2(STORAGE_SIZE) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          mapping_en,
  input  logic          valid_data,
  input  logic          new_line,
  input  logic          new_character,
  input  logic [7:0]    incoming_character,
  input  logic [PW-1:0] pc,
  input  logic [LW-1:0] query_label,
  output logic          query_hit,
  output logic [PW-1:0] query_pc,
  output logic [CW-1:0] label_count,
  output logic          done_flag,
  output logic          error_flag
);
  typedef enum logic [2:0] {LINE_START, COLLECT, COMMIT, SKIP, ERROR} state_t;

  state_t        state, state_d;
  logic [LW-1:0] lbuf, lbuf_d;
  logic [NW-1:0] cnt, cnt_d;
  logic [PW-1:0] pc_q;
  logic          latch_pc, wr, dup, full;
  logic          line_ev, chr_ev, is_letter, is_blank;
  logic [4:0]    code;
  logic [IW-1:0] idx;

  logic [STORAGE_SIZE-1:0] ent_vld;
  logic [LW-1:0]           ent_lbl [STORAGE_SIZE];
  logic [PW-1:0]           ent_pc  [STORAGE_SIZE];

  // new_line wins over a simultaneous character, which is dropped
  assign line_ev   = valid_data && mapping_en && new_line;
  assign chr_ev    = valid_data && mapping_en && new_character && !new_line;
  assign code      = incoming_character[4:0];
  assign is_letter = (incoming_character >= 8'h61 && incoming_character <= 8'h7a) ||
                     (incoming_character >= 8'h41 && incoming_character <= 8'h5a);
  assign is_blank  = (incoming_character == 8'h20) || (incoming_character == 8'h09);
  assign full      = (label_count == CW'(STORAGE_SIZE));
  assign idx       = label_count[IW-1:0];
  assign error_flag = (state == ERROR);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= LINE_START;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    lbuf_d   = lbuf;
    cnt_d    = cnt;
    latch_pc = 1'b0;
    wr       = 1'b0;
    case (state)
      LINE_START: begin
        if (line_ev) begin
          lbuf_d = '0;
          cnt_d  = '0;
        end else if (chr_ev && !is_blank) begin
          if (is_letter) begin
            state_d = COLLECT;
            lbuf_d  = {{(LW-5){1'b0}}, code};
            cnt_d   = NW'(1);
          end else begin
            state_d = SKIP;
          end
        end
      end
      COLLECT: begin
        if (line_ev) begin
          state_d = LINE_START;
          lbuf_d  = '0;
          cnt_d   = '0;
        end else if (chr_ev) begin
          if (is_letter) begin
            if (cnt == NW'(NUMBER_LETTERS)) begin
              state_d = ERROR;
            end else begin
              lbuf_d = {lbuf[LW-6:0], code};
              cnt_d  = cnt + NW'(1);
            end
          end else if (incoming_character == 8'h3a) begin
            state_d  = COMMIT;
            latch_pc = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      COMMIT: begin
        if (full || dup) begin
          state_d = ERROR;
        end else begin
          wr      = 1'b1;
          state_d = SKIP;
          // a line break seen during the commit cycle still ends the line
          if (line_ev) begin
            state_d = LINE_START;
            lbuf_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      SKIP: begin
        if (line_ev) begin
          state_d = LINE_START;
          lbuf_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lbuf        <= '0;
      cnt         <= '0;
      pc_q        <= '0;
      ent_vld     <= '0;
      label_count <= '0;
      done_flag   <= 1'b0;
      for (int i = 0; i < STORAGE_SIZE; i++) begin
        ent_lbl[i] <= '0;
        ent_pc[i]  <= '0;
      end
    end else begin
      lbuf      <= lbuf_d;
      cnt       <= cnt_d;
      done_flag <= wr;
      if (latch_pc) pc_q <= pc;
      if (wr) begin
        ent_vld[idx] <= 1'b1;
        ent_lbl[idx] <= lbuf;
        ent_pc[idx]  <= pc_q;
        label_count  <= label_count + CW'(1);
      end
    end
  end

  // descending scan so the lowest matching index is the one that sticks
  always_comb begin
    query_hit = 1'b0;
    query_pc  = '0;
    for (int i = STORAGE_SIZE - 1; i >= 0; i--) begin
      if (ent_vld[i] && ent_lbl[i] == query_label) begin
        query_hit = 1'b1;
        query_pc  = ent_pc[i];
      end
    end
  end

`ifdef LABEL_DUP_CHECK_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < STORAGE_SIZE; i++)
      if (ent_vld[i] && ent_lbl[i] == lbuf) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_label_definition_collector.sv
// Self-checking bench for label_definition_collector: directed scenarios plus
// randomized lines checked against a line-level parsing model.
module tb_label_definition_collector;
  localparam int N  = 6;
  localparam int S  = 8;
  localparam int PW = 8;
  localparam int LW = N * 5;
  localparam int CW = 4;

  logic          clk_in = 1'b0, rst_in = 1'b1, mapping_en = 1'b1;
  logic          valid_data = 1'b0, new_line = 1'b0, new_character = 1'b0;
  logic [7:0]    incoming_character = '0;
  logic [PW-1:0] pc = '0;
  logic [LW-1:0] query_label = '0;
  logic          query_hit, done_flag, error_flag;
  logic [PW-1:0] query_pc;
  logic [CW-1:0] label_count;

  int n_checks = 0, n_fail = 0, done_cnt = 0;

  typedef struct {logic [LW-1:0] lbl; logic [PW-1:0] pc;} ent_t;
  ent_t m_tab[$];
  bit   m_err;
  string instrs[5] = '{"addi x1, x0, 5", "  jal x0 loop", "beq x1,x2,end", "# comment", ""};

  label_definition_collector dut (
    .clk_in(clk_in), .rst_in(rst_in), .mapping_en(mapping_en), .valid_data(valid_data),
    .new_line(new_line), .new_character(new_character), .incoming_character(incoming_character),
    .pc(pc), .query_label(query_label), .query_hit(query_hit), .query_pc(query_pc),
    .label_count(label_count), .done_flag(done_flag), .error_flag(error_flag));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (done_flag) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic bit letter(input byte b);
    return (b >= "a" && b <= "z") || (b >= "A" && b <= "Z");
  endfunction

  function automatic logic [LW-1:0] enc(input string s);
    logic [LW-1:0] e = '0;
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      e = {e[LW-6:0], b[4:0]};
    end
    return e;
  endfunction

  // applies one complete source line to the reference table
  function automatic void model_line(input string s, input logic [PW-1:0] p);
    int i = 0, n = 0;
    logic [LW-1:0] e = '0;
    byte b;
    if (m_err) return;
    while (i < s.len()) begin
      b = s[i];
      if (b == " " || b == "\t") i++; else break;
    end
    while (i < s.len()) begin
      b = s[i];
      if (!letter(b)) break;
      if (n == N) begin m_err = 1; return; end
      e = {e[LW-6:0], b[4:0]};
      n++; i++;
    end
    if (n == 0 || i >= s.len()) return;
    b = s[i];
    if (b != ":") return;
    if (m_tab.size() == S) begin m_err = 1; return; end
`ifdef LABEL_DUP_CHECK_EN
    foreach (m_tab[k]) if (m_tab[k].lbl == e) begin m_err = 1; return; end
`endif
    m_tab.push_back('{lbl: e, pc: p});
  endfunction

  function automatic void model_lookup(input logic [LW-1:0] q, output logic hit, output logic [PW-1:0] p);
    hit = 1'b0; p = '0;
    foreach (m_tab[k]) if (m_tab[k].lbl == q) begin hit = 1'b1; p = m_tab[k].pc; return; end
  endfunction

  function automatic string rand_name(input int len);
    string s = "";
    for (int i = 0; i < len; i++)
      s = {s, $sformatf("%c", 8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 3))))};
    return s;
  endfunction

  function automatic string make_line();
    string s = "";
    if ($urandom_range(0, 9) < 5) begin
      if ($urandom_range(0, 1) == 1) s = "  ";
      s = {s, rand_name(($urandom_range(0, 9) == 0) ? 7 : $urandom_range(1, 3)), ":"};
      if ($urandom_range(0, 1) == 1) s = {s, " addi x1, x0, 1"};
    end else begin
      s = instrs[$urandom_range(0, 4)];
    end
    return s;
  endfunction

  // every driving task starts and returns at a falling edge
  task automatic ev(input logic nl, input logic nc, input byte c);
    valid_data = 1'b1; new_line = nl; new_character = nc; incoming_character = c;
    @(negedge clk_in);
    valid_data = 1'b0; new_line = 1'b0; new_character = 1'b0;
  endtask

  task automatic chr(input byte c);
    ev(1'b0, 1'b1, c);
  endtask

  task automatic nl();
    ev(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_line(input string s, input logic [PW-1:0] p);
    pc = p;
    for (int i = 0; i < s.len(); i++) chr(s[i]);
    nl();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b0;
    m_tab.delete();
    m_err = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    query_label = enc("a"); #1;
    n_checks++;
    if (label_count !== 0 || error_flag !== 0 || done_flag !== 0 || query_hit !== 0 || query_pc !== 0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d err=%0b done=%0b hit=%0b pc=%0d, want all 0",
               label_count, error_flag, done_flag, query_hit, query_pc);
    end
  endtask

  task automatic test_basic();
    int d0;
    do_reset();
    d0 = done_cnt;
    pc = 8'd3;
    chr("l"); chr("o"); chr("o"); chr("p"); chr(":");
    n_checks++;
    if (done_flag !== 0 || label_count !== 0) begin
      n_fail++; $display("FAIL basic_commit_cycle: done=%0b count=%0d, want 0 0", done_flag, label_count);
    end
    nl();
    n_checks++;
    if (done_flag !== 1 || label_count !== 1) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%0b count=%0d, want 1 1", done_flag, label_count);
    end
    @(negedge clk_in);
    n_checks++;
    if (done_flag !== 0) begin n_fail++; $display("FAIL basic_done_clear: done=%0b, want 0", done_flag); end
    @(negedge clk_in);
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0); end
    query_label = enc("LOOP"); #1;
    n_checks++;
    if (query_hit !== 1 || query_pc !== 8'd3) begin
      n_fail++; $display("FAIL basic_query_loop: hit=%0b pc=%0d, want 1 3", query_hit, query_pc);
    end
    query_label = enc("lop"); #1;
    n_checks++;
    if (query_hit !== 0 || query_pc !== 0) begin
      n_fail++; $display("FAIL basic_query_lop: hit=%0b pc=%0d, want 0 0", query_hit, query_pc);
    end
  endtask

  task automatic test_mnemonic();
    int d0;
    do_reset();
    d0 = done_cnt;
    send_line("addi x1, x0, 5", 8'd0);
    repeat (2) @(negedge clk_in);
    n_checks++;
    if (label_count !== 0 || error_flag !== 0 || done_cnt != d0) begin
      n_fail++; $display("FAIL mnemonic: count=%0d err=%0b done=%0d, want 0 0 0", label_count, error_flag, done_cnt - d0);
    end
  endtask

  task automatic test_too_long();
    do_reset();
    chr("a"); chr("b"); chr("c"); chr("d"); chr("e"); chr("f");
    n_checks++;
    if (error_flag !== 0) begin n_fail++; $display("FAIL too_long_six_ok: err=%0b, want 0", error_flag); end
    chr("g");
    n_checks++;
    if (error_flag !== 1) begin n_fail++; $display("FAIL too_long_seventh: err=%0b, want 1", error_flag); end
    chr(":"); nl(); @(negedge clk_in);
    n_checks++;
    if (error_flag !== 1 || label_count !== 0) begin
      n_fail++; $display("FAIL too_long_sticky: err=%0b count=%0d, want 1 0", error_flag, label_count);
    end
    do_reset();
    n_checks++;
    if (error_flag !== 0 || label_count !== 0) begin
      n_fail++; $display("FAIL too_long_reset: err=%0b count=%0d, want 0 0", error_flag, label_count);
    end
  endtask

  task automatic test_table_full();
    do_reset();
    for (int i = 0; i < S; i++) send_line($sformatf("%c:", 8'(8'h61 + i)), PW'(i));
    repeat (2) @(negedge clk_in);
    n_checks++;
    if (label_count !== CW'(S) || error_flag !== 0) begin
      n_fail++; $display("FAIL full_eight: count=%0d err=%0b, want 8 0", label_count, error_flag);
    end
    send_line("i:", 8'd8);
    repeat (2) @(negedge clk_in);
    query_label = enc("i"); #1;
    n_checks++;
    if (error_flag !== 1 || label_count !== CW'(S) || query_hit !== 0) begin
      n_fail++; $display("FAIL full_ninth: err=%0b count=%0d hit=%0b, want 1 8 0", error_flag, label_count, query_hit);
    end
    query_label = enc("h"); #1;
    n_checks++;
    if (query_hit !== 1 || query_pc !== 8'd7) begin
      n_fail++; $display("FAIL full_query_h: hit=%0b pc=%0d, want 1 7", query_hit, query_pc);
    end
  endtask

  task automatic test_split_line();
    do_reset();
    pc = 8'd4;
    chr("l"); chr("o"); nl();
    pc = 8'd5;
    chr("o"); chr("p"); chr(":"); nl();
    ev(1'b1, 1'b1, "x");
    send_line("y:", 8'd6);
    repeat (2) @(negedge clk_in);
    query_label = enc("op"); #1;
    n_checks++;
    if (query_hit !== 1 || query_pc !== 8'd5) begin
      n_fail++; $display("FAIL split_query_op: hit=%0b pc=%0d, want 1 5", query_hit, query_pc);
    end
    query_label = enc("loop"); #1;
    n_checks++;
    if (query_hit !== 0) begin n_fail++; $display("FAIL split_query_loop: hit=%0b, want 0", query_hit); end
    query_label = enc("y"); #1;
    n_checks++;
    if (query_hit !== 1 || query_pc !== 8'd6 || label_count !== 2) begin
      n_fail++; $display("FAIL split_drop_char: hit=%0b pc=%0d count=%0d, want 1 6 2", query_hit, query_pc, label_count);
    end
  endtask

  task automatic test_mapping_disabled();
    do_reset();
    pc = 8'd9;
    chr("a"); chr("b");
    mapping_en = 1'b0;
    chr("c"); nl(); chr("q");
    mapping_en = 1'b1;
    chr(":"); nl();
    repeat (2) @(negedge clk_in);
    query_label = enc("ab"); #1;
    n_checks++;
    if (query_hit !== 1 || query_pc !== 8'd9 || label_count !== 1) begin
      n_fail++; $display("FAIL mapping_hold: hit=%0b pc=%0d count=%0d, want 1 9 1", query_hit, query_pc, label_count);
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    send_line("x:", 8'd1);
    send_line("x:", 8'd4);
    repeat (2) @(negedge clk_in);
    query_label = enc("x"); #1;
    n_checks++;
`ifdef LABEL_DUP_CHECK_EN
    if (error_flag !== 1 || label_count !== 1 || query_pc !== 8'd1) begin
      n_fail++; $display("FAIL duplicate: err=%0b count=%0d pc=%0d, want 1 1 1", error_flag, label_count, query_pc);
    end
`else
    if (error_flag !== 0 || label_count !== 2 || query_hit !== 1 || query_pc !== 8'd1) begin
      n_fail++; $display("FAIL duplicate: err=%0b count=%0d hit=%0b pc=%0d, want 0 2 1 1",
                         error_flag, label_count, query_hit, query_pc);
    end
`endif
  endtask

  task automatic test_random();
    int d0;
    string s;
    logic eh;
    logic [PW-1:0] ep;
    for (int r = 0; r < 20; r++) begin
      do_reset();
      d0 = done_cnt;
      for (int l = 0; l < 10; l++) begin
        s = make_line();
        model_line(s, PW'(l));
        send_line(s, PW'(l));
      end
      repeat (3) @(negedge clk_in);
      n_checks++;
      if (label_count !== CW'(m_tab.size()) || error_flag !== m_err || done_cnt - d0 != m_tab.size()) begin
        n_fail++;
        $display("FAIL random_state r%0d: count=%0d err=%0b done=%0d, want %0d %0b %0d",
                 r, label_count, error_flag, done_cnt - d0, m_tab.size(), m_err, m_tab.size());
      end
      for (int q = 0; q < 6; q++) begin
        query_label = (q < m_tab.size()) ? m_tab[q].lbl : enc(rand_name($urandom_range(1, 3)));
        model_lookup(query_label, eh, ep);
        #1;
        n_checks++;
        if (query_hit !== eh || query_pc !== ep) begin
          n_fail++;
          $display("FAIL random_query r%0d q%0d: hit=%0b pc=%0d, want %0b %0d", r, q, query_hit, query_pc, eh, ep);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mnemonic();
    test_too_long();
    test_table_full();
    test_split_line();
    test_mapping_disabled();
    test_duplicate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
